// File: rtl/div_pkg.sv
// Shared encodings for the programmable clock divider.
// Controller states and the smallest legal divisor.
`timescale 1ns/1ps
package div_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/div_core.sv
// Period counter and 50%-duty waveform generator.
// Odd divisors use a negedge copy to get the half-cycle.
`timescale 1ns/1ps
module div_core
  import div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] div_i,
  input  logic             run_i,
  input  logic             load_i,
  output logic             boundary_o,
  output logic             clk_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last;
  logic [CNT_W:0]   half;
  logic             act_q;
  logic             p_q;
  logic             p_d;
  logic             n_q;

  // One extra bit so N = 2^CNT_W-1 cannot overflow.
  assign last = div_i - CNT_W'(1);
  assign half = ({1'b0, div_i} + (CNT_W+1)'(1)) >> 1;

  assign boundary_o = act_q && (cnt_q == last);

  // Next count and next high/low level of the posedge phase.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!run_i || !act_q || boundary_o || load_i) begin
      cnt_d = '0;
    end
    p_d = run_i && ({1'b0, cnt_d} < half);
  end

  // Counter and posedge phase; first active edge starts at cnt 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= 1'b0;
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      act_q <= run_i;
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  // Half-cycle delayed copy used to trim odd-N high time.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  assign clk_o = div_i[0] ? (p_q & n_q) : p_q;

endmodule

// File: rtl/div_ctrl.sv
// Runtime-programmable clock divider with boundary-synchronous
// divisor changes and clean start/stop sequencing.
`timescale 1ns/1ps
module div_ctrl
  import div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_tick,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  state_e           state_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend_q;
  logic             err_q;

  logic accept;
  logic legal;
  logic boundary;
  logic stop;
  logic load;
  logic run;

  assign cfg_ready = (state_q != ST_PEND);
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = (cfg_div >= CNT_W'(DIV_MIN));

  assign stop = (state_q != ST_OFF) && boundary && !en;
  assign load = boundary && (state_q == ST_PEND);
  assign run  = (state_q != ST_OFF) && !stop;

  assign cfg_err     = err_q;
  assign period_tick = boundary;
  assign busy        = (state_q != ST_OFF);

  // Sequencer: handshake, pending divisor and boundary-only switching.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      div_q   <= DEF;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      unique case (state_q)
        ST_OFF: begin
          if (accept && legal) div_q <= cfg_div;
          if (en) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            // Stopping anyway, so a same-edge accept loads directly.
            state_q <= ST_OFF;
            if (accept && legal) div_q <= cfg_div;
          end else if (accept && legal) begin
            pend_q  <= cfg_div;
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (boundary) begin
            div_q   <= pend_q;
            state_q <= en ? ST_RUN : ST_OFF;
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_i     (clk_in),
    .rst_ni    (rst),
    .div_i     (div_q),
    .run_i     (run),
    .load_i    (load),
    .boundary_o(boundary),
    .clk_o     (clk_out)
  );

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: expected pulses are queued by
// the stimulus and popped by a clk_out monitor.
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             period_tick;
  logic             busy;

  typedef struct {
    int hi;
    int per;
  } pulse_t;

  pulse_t sb[$];
  int     n_vec = 0;
  int     n_fail = 0;
  int     err_cnt = 0;
  longint last_rise = 0;
  longint prev_rise = 0;

  div_ctrl #(
    .CNT_W  (CNT_W),
    .DEF_DIV(5)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .period_tick(period_tick),
    .busy       (busy)
  );

  always #10 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic expect_pulse(input int per, input int hi);
    pulse_t e;
    e.hi  = hi;
    e.per = per;
    sb.push_back(e);
  endtask

  task automatic sync_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk_in);
      k++;
    end while (!period_tick && k < 64);
    if (!period_tick) chk("tick_timeout", int'(period_tick), 1);
  endtask

  task automatic send_cfg(input int d);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(d);
    @(posedge clk_in);
    #1 cfg_valid = 1'b0;
  endtask

  always @(posedge clk_out) begin
    prev_rise = last_rise;
    last_rise = $time;
  end

  always @(negedge clk_out) begin
    pulse_t e;
    int hi;
    int per;
    if (rst) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL pulse_unexpected: got pulse ending %0t, expected none",
                 $time);
      end else begin
        e   = sb.pop_front();
        hi  = int'($time - last_rise);
        per = int'(last_rise - prev_rise);
        chk("pulse_high", hi, e.hi);
        if (e.per != 0) chk("pulse_period", per, e.per);
      end
    end
  end

  always @(negedge clk_in) begin
    if (cfg_err) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish by 2ms");
    $fatal(1);
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk_in);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_err", int'(cfg_err), 0);
    rst = 1'b1;
    #1 chk("rst_ready", int'(cfg_ready), 1);

    // N=5 from reset
    expect_pulse(0, 50);
    repeat (3) expect_pulse(100, 50);
    en = 1'b1;
    @(posedge clk_in);
    #1 chk("start_busy", int'(busy), 1);
    chk("start_low", int'(clk_out), 0);
    sync_tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("tick_pattern", int'(period_tick), int'(i == 4));
    end
    sync_tick();
    sync_tick();
    chk("sb_drain1", sb.size(), 0);

    // 5 -> 4 mid-period
    expect_pulse(100, 50);
    expect_pulse(90, 40);
    expect_pulse(80, 40);
    expect_pulse(80, 40);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 send_cfg(4);
    chk("ready_pend", int'(cfg_ready), 0);
    sync_tick();
    chk("ready_pend_tick", int'(cfg_ready), 0);
    sync_tick();
    chk("ready_back", int'(cfg_ready), 1);
    sync_tick();
    sync_tick();
    chk("sb_drain2", sb.size(), 0);

    // accept on the tick cycle: applies one boundary later
    expect_pulse(80, 40);
    expect_pulse(90, 50);
    expect_pulse(100, 50);
    chk("ready_on_tick", int'(cfg_ready), 1);
    send_cfg(5);
    repeat (3) sync_tick();
    expect_pulse(100, 50);
    expect_pulse(90, 40);
    expect_pulse(80, 40);
    send_cfg(4);
    repeat (3) sync_tick();
    chk("sb_drain3", sb.size(), 0);

    // illegal divisors
    e0 = err_cnt;
    repeat (3) expect_pulse(80, 40);
    @(posedge clk_in);
    #1 send_cfg(1);
    @(posedge clk_in);
    #1 send_cfg(0);
    repeat (3) sync_tick();
    chk("err_pulses", err_cnt - e0, 2);
    chk("ready_after_err", int'(cfg_ready), 1);
    chk("busy_after_err", int'(busy), 1);

    // N=6, stop at boundary, restart
    expect_pulse(80, 40);
    expect_pulse(80, 60);
    expect_pulse(120, 60);
    @(posedge clk_in);
    #1 send_cfg(6);
    repeat (3) sync_tick();
    expect_pulse(120, 60);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 en = 1'b0;
    sync_tick();
    chk("busy_draining", int'(busy), 1);
    @(negedge clk_in);
    chk("busy_off", int'(busy), 0);
    chk("off_low", int'(clk_out), 0);
    repeat (3) @(negedge clk_in);
    chk("off_stays_low", int'(clk_out), 0);
    chk("sb_drain4", sb.size(), 0);
    expect_pulse(0, 60);
    expect_pulse(120, 60);
    expect_pulse(120, 60);
    @(posedge clk_in);
    #1 en = 1'b1;
    @(posedge clk_in);
    #1 chk("restart_busy", int'(busy), 1);
    chk("restart_low", int'(clk_out), 0);
    @(posedge clk_in);
    #1 chk("restart_rise", int'(clk_out), 1);
    sync_tick();
    @(posedge clk_in);
    @(posedge clk_in);
    #1 en = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 en = 1'b1;
    sync_tick();
    sync_tick();
    chk("cancel_busy", int'(busy), 1);
    chk("sb_drain5", sb.size(), 0);

    // reset mid-high with a pending divisor
    @(posedge clk_in);
    #1 send_cfg(3);
    chk("ready_pend6", int'(cfg_ready), 0);
    chk("high_before_rst", int'(clk_out), 1);
    #4 rst = 1'b0;
    #1 chk("rst_mid_low", int'(clk_out), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(cfg_ready), 1);
    expect_pulse(0, 50);
    expect_pulse(100, 50);
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    sync_tick();
    sync_tick();
    en = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("end_busy", int'(busy), 0);
    chk("sb_drain6", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
